// File: rtl/pet_needs_engine.sv
// Need/health engine for the virtual pet: per-channel decaying needs, shared health,
// channel select, hold-to-toggle test mode and care events.
module pet_needs_engine #(
   parameter int unsigned N_NEEDS       = 5,
   parameter int unsigned LVL_W         = 3,
   parameter int unsigned PER_W         = 16,
   parameter int unsigned TICK_CYCLES   = 50_000_000,
   parameter int unsigned HOLD_CYCLES   = 250_000_000,
   parameter int unsigned HEALTH_PERIOD = 60,
   parameter int unsigned CARE_STEP     = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       btn_test,
   input  logic                       btn_next,
   input  logic                       btn_dec,
   input  logic                       care_valid,
   input  logic [2:0]                 care_ch,
   input  logic [N_NEEDS*PER_W-1:0]   decay_period,
   output logic [N_NEEDS*LVL_W-1:0]   levels,
   output logic [LVL_W-1:0]           health,
   output logic [2:0]                 sel,
   output logic                       test_mode,
   output logic                       dead,
   output logic [N_NEEDS-1:0]         alarm,
   output logic                       tick
);

   localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned HP_W   = (HEALTH_PERIOD > 1) ? $clog2(HEALTH_PERIOD) : 1;
   localparam logic [LVL_W-1:0] MAX = {LVL_W{1'b1}};

   logic [TICK_W-1:0] tick_cnt;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
   logic [HP_W-1:0]   hcnt, hcnt_n;
   logic [PER_W-1:0]  dcnt   [N_NEEDS];
   logic [PER_W-1:0]  dcnt_n [N_NEEDS];
   logic [LVL_W-1:0]  lvl    [N_NEEDS];
   logic [LVL_W-1:0]  lvl_n  [N_NEEDS];
   logic [LVL_W-1:0]  health_n, sel_lvl;
   logic [2:0]        sel_n;
   logic              test_mode_n;
   logic              prev_next, prev_dec;
   logic              tick_evt, next_rise, dec_rise, care_hit;
   logic              dec_lvl, dec_health, hstep_evt;
   logic [N_NEEDS-1:0] decay_hit;
   int                h_tmp;

   assign tick_evt  = (tick_cnt == TICK_W'(TICK_CYCLES - 1));
   assign next_rise = btn_next & ~prev_next;
   assign dec_rise  = btn_dec & ~prev_dec;
   assign care_hit  = care_valid && ({1'b0, care_ch} < 4'(N_NEEDS));
   assign hstep_evt = tick_evt && (hcnt == HP_W'(HEALTH_PERIOD - 1));

   // Level of the selected channel decides whether a test decrement hits the need or health.
   always_comb begin
      sel_lvl = '0;
      for (int i = 0; i < N_NEEDS; i++) begin
         if (sel == 3'(i)) sel_lvl = lvl[i];
      end
   end

   assign dec_lvl    = test_mode && dec_rise && (sel_lvl != '0);
   assign dec_health = test_mode && dec_rise && (sel_lvl == '0);

   // Output packing and alarms straight from the level registers.
   always_comb begin
      levels = '0;
      alarm  = '0;
      for (int i = 0; i < N_NEEDS; i++) begin
         levels[i*LVL_W +: LVL_W] = lvl[i];
         alarm[i]                 = (lvl[i] == '0);
      end
   end

   // Per-channel next state: care beats test decrement beats decay.
   always_comb begin
      decay_hit = '0;
      for (int i = 0; i < N_NEEDS; i++) begin
         lvl_n[i]  = lvl[i];
         dcnt_n[i] = dcnt[i];
         if (decay_period[i*PER_W +: PER_W] == '0) begin
            dcnt_n[i] = '0;
         end else if (tick_evt) begin
            if (dcnt[i] >= decay_period[i*PER_W +: PER_W] - PER_W'(1)) begin
               dcnt_n[i]    = '0;
               decay_hit[i] = 1'b1;
            end else begin
               dcnt_n[i] = dcnt[i] + PER_W'(1);
            end
         end
         if (care_hit && (care_ch == 3'(i))) begin
            dcnt_n[i] = '0;
            if (32'(lvl[i]) + CARE_STEP >= 32'(MAX)) lvl_n[i] = MAX;
            else lvl_n[i] = lvl[i] + LVL_W'(CARE_STEP);
         end else if (dec_lvl && (sel == 3'(i))) begin
            lvl_n[i] = lvl[i] - LVL_W'(1);
         end else if (decay_hit[i] && (lvl[i] != '0)) begin
            lvl_n[i] = lvl[i] - LVL_W'(1);
         end
      end
   end

   // Health, selection and test-mode next state.
   always_comb begin
      hcnt_n      = hcnt;
      hold_cnt_n  = hold_cnt;
      test_mode_n = test_mode;
      sel_n       = sel;
      h_tmp       = int'(health);
      if (tick_evt) hcnt_n = hstep_evt ? '0 : hcnt + HP_W'(1);
      if (hstep_evt) h_tmp = (alarm != '0) ? h_tmp - 1 : h_tmp + 1;
      if (dec_health) h_tmp = h_tmp - 1;
      if (h_tmp < 0) health_n = '0;
      else if (h_tmp > int'(MAX)) health_n = MAX;
      else health_n = LVL_W'(h_tmp);
      if (!btn_test) begin
         hold_cnt_n = '0;
      end else if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
         hold_cnt_n  = '0;
         test_mode_n = ~test_mode;
      end else begin
         hold_cnt_n = hold_cnt + HOLD_W'(1);
      end
      if (next_rise) sel_n = (sel == 3'(N_NEEDS - 1)) ? 3'd0 : sel + 3'd1;
   end

   // State registers; everything but the tick timebase freezes once dead.
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt  <= '0;
         tick      <= 1'b0;
         prev_next <= 1'b0;
         prev_dec  <= 1'b0;
         hold_cnt  <= '0;
         hcnt      <= '0;
         health    <= MAX;
         sel       <= '0;
         test_mode <= 1'b0;
         dead      <= 1'b0;
         for (int i = 0; i < N_NEEDS; i++) begin
            lvl[i]  <= MAX;
            dcnt[i] <= '0;
         end
      end else begin
         tick_cnt  <= tick_evt ? '0 : tick_cnt + TICK_W'(1);
         tick      <= tick_evt;
         prev_next <= btn_next;
         prev_dec  <= btn_dec;
         if (!dead) begin
            hold_cnt  <= hold_cnt_n;
            hcnt      <= hcnt_n;
            health    <= health_n;
            sel       <= sel_n;
            test_mode <= test_mode_n;
            dead      <= (health_n == '0);
            for (int i = 0; i < N_NEEDS; i++) begin
               lvl[i]  <= lvl_n[i];
               dcnt[i] <= dcnt_n[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_pet_needs_engine.sv
// Scoreboard bench for pet_needs_engine: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pet_needs_engine;

   localparam int unsigned N  = 5;
   localparam int unsigned LW = 3;
   localparam int unsigned PW = 16;

   localparam int F_H = 8, F_SEL = 9, F_TM = 10, F_DEAD = 11, F_ALARM = 12, F_TICK = 13, F_LVLS = 14;

   logic            clk = 1'b0;
   logic            reset, btn_test, btn_next, btn_dec, care_valid;
   logic [2:0]      care_ch;
   logic [N*PW-1:0] decay_period;
   logic [N*LW-1:0] levels;
   logic [LW-1:0]   health;
   logic [2:0]      sel;
   logic            test_mode, dead, tick;
   logic [N-1:0]    alarm;

   typedef struct {
      string name;
      int    field;
      int    exp;
   } exp_t;

   exp_t sb[$];
   logic req = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pet_needs_engine #(
      .N_NEEDS(N), .LVL_W(LW), .PER_W(PW), .TICK_CYCLES(4),
      .HOLD_CYCLES(8), .HEALTH_PERIOD(3), .CARE_STEP(2)
   ) dut (
      .clk(clk), .reset(reset), .btn_test(btn_test), .btn_next(btn_next),
      .btn_dec(btn_dec), .care_valid(care_valid), .care_ch(care_ch),
      .decay_period(decay_period), .levels(levels), .health(health), .sel(sel),
      .test_mode(test_mode), .dead(dead), .alarm(alarm), .tick(tick)
   );

   function automatic int get_field(input int f);
      if (f < int'(N)) return int'(levels[f*LW +: LW]);
      case (f)
         F_H:     return int'(health);
         F_SEL:   return int'(sel);
         F_TM:    return int'(test_mode);
         F_DEAD:  return int'(dead);
         F_ALARM: return int'(alarm);
         F_TICK:  return int'(tick);
         F_LVLS:  return int'(levels);
         default: return -1;
      endcase
   endfunction

   // Monitor: compares every queued expectation once the driver flags a sample point.
   initial begin
      exp_t e;
      int   act;
      forever begin
         @(negedge clk);
         if (req) begin
            while (sb.size() > 0) begin
               e   = sb.pop_front();
               act = get_field(e.field);
               checks++;
               if (act != e.exp) begin
                  errors++;
                  $display("FAIL %s: actual=%0d required=%0d", e.name, act, e.exp);
               end
            end
            req = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int field, input int exp);
      exp_t e;
      e.name  = name;
      e.field = field;
      e.exp   = exp;
      sb.push_back(e);
      req = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1);
      reset = 1'b0;
   endtask

   task automatic pulse_dec();
      btn_dec = 1'b1;
      step(1);
      btn_dec = 1'b0;
      step(1);
   endtask

   task automatic pulse_next();
      btn_next = 1'b1;
      step(1);
      btn_next = 1'b0;
      step(1);
   endtask

   task automatic care(input logic [2:0] ch);
      care_valid = 1'b1;
      care_ch    = ch;
      step(1);
      care_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; btn_test = 1'b0; btn_next = 1'b0; btn_dec = 1'b0;
      care_valid = 1'b0; care_ch = 3'd0; decay_period = '0;

      // Decay on ch0 only, tick cadence, health recovery saturates
      decay_period[0 +: PW] = 16'd2;
      do_reset();
      chk("rst_levels", F_LVLS, 32767); chk("rst_health", F_H, 7); chk("rst_sel", F_SEL, 0);
      chk("rst_tm", F_TM, 0); chk("rst_dead", F_DEAD, 0); chk("rst_alarm", F_ALARM, 0);
      chk("rst_tick", F_TICK, 0);
      step(3);  chk("tick_low", F_TICK, 0);
      step(1);  chk("tick_first", F_TICK, 1); chk("lvl0_t1", 0, 7);
      step(1);  chk("tick_one_cycle", F_TICK, 0);
      step(3);  chk("lvl0_t2", 0, 6);
      step(8);  chk("lvl0_t4", 0, 5); chk("lvl1_hold", 1, 7); chk("lvl4_hold", 4, 7);
      chk("health_sat", F_H, 7); chk("tick_t4", F_TICK, 1);

      // Hold-to-toggle test mode
      decay_period = '0;
      do_reset();
      btn_test = 1'b1;
      step(7); chk("tm_hold7", F_TM, 0);
      step(1); chk("tm_on", F_TM, 1);
      step(8); chk("tm_off", F_TM, 0);
      step(7); btn_test = 1'b0;
      step(1); chk("tm_release7", F_TM, 0);

      // Test decrements drive level0 to zero, then health to death; dead freezes state
      do_reset();
      btn_test = 1'b1; step(8); btn_test = 1'b0;
      chk("tm_enter", F_TM, 1);
      repeat (7) pulse_dec();
      chk("lvl0_zero", 0, 0); chk("alarm0", F_ALARM, 1); chk("health_pre", F_H, 7);
      pulse_dec();
      chk("health_dec_and_step", F_H, 5);
      repeat (6) pulse_dec();
      chk("health_zero", F_H, 0); chk("dead_set", F_DEAD, 1);
      pulse_next();
      care(3'd0); step(1);
      chk("dead_sel_frozen", F_SEL, 0); chk("dead_lvl0_frozen", 0, 0);
      chk("dead_tm_frozen", F_TM, 1); chk("dead_sticky", F_DEAD, 1); chk("dead_tick_runs", F_TICK, 1);

      // Channel select: held button acts once, wrap from last channel
      do_reset();
      btn_next = 1'b1; step(20);
      chk("sel_held_once", F_SEL, 1);
      btn_next = 1'b0; step(1);
      repeat (3) pulse_next();
      chk("sel_4", F_SEL, 4);
      pulse_next();
      chk("sel_wrap", F_SEL, 0);
      repeat (4) pulse_next();
      chk("sel_back_4", F_SEL, 4);

      // Care against a same-cycle decay compare, out-of-range care, care clears decay counter
      decay_period = '0;
      decay_period[2*PW +: PW] = 16'd2;
      do_reset();
      step(8);  chk("lvl2_decay", 2, 6);
      step(7);  care(3'd2);
      chk("care_beats_decay", 2, 7);
      step(7);  chk("lvl2_no_decay_yet", 2, 7);
      step(1);  chk("lvl2_decay_again", 2, 6);
      care(3'd6);
      chk("care_ch6_ignored", F_LVLS, 32703);
      step(3);  care(3'd2);
      chk("care_sat", 2, 7);
      step(3);  chk("care_cleared_cnt", 2, 7);
      step(4);  chk("decay_after_clear", 2, 6);

      // Alarm-driven health decay, care recovery, reset mid-count
      decay_period = '0;
      do_reset();
      btn_test = 1'b1; step(8); btn_test = 1'b0;
      pulse_next();
      repeat (7) pulse_dec();
      chk("lvl1_zero", 1, 0); chk("alarm1", F_ALARM, 2); chk("health_alarm_step", F_H, 6);
      btn_test = 1'b1; step(8); btn_test = 1'b0;
      chk("tm_exit", F_TM, 0); chk("health_hold", F_H, 6);
      step(3);  chk("health_before_step", F_H, 6);
      step(1);  chk("health_step_dec", F_H, 5);
      care(3'd1);
      chk("care_from_zero", 1, 2); chk("alarm_cleared", F_ALARM, 0);
      reset = 1'b1; step(1);
      chk("mid_rst_levels", F_LVLS, 32767); chk("mid_rst_health", F_H, 7);
      chk("mid_rst_sel", F_SEL, 0); chk("mid_rst_tm", F_TM, 0); chk("mid_rst_dead", F_DEAD, 0);
      chk("mid_rst_alarm", F_ALARM, 0); chk("mid_rst_tick", F_TICK, 0);
      reset = 1'b0;
      step(2);

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: actual=%0d required=0 pending entries", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pet_needs_engine.md
Name: pet_needs_engine

Overview:
Parametrised need/health engine for the virtual-pet top level. It tracks N independent need levels. Each level decays on its own programmable period, and a shared health level depends on the needs. The block owns channel selection, a hold-to-toggle test mode and care (replenish) events. The face/icon renderer and the 7-segment formatter consume its outputs; the block drives no display itself.

Parameters:
N_NEEDS, 5, number of need channels (2..8)
LVL_W, 3, width of each need level and of health; MAX = 2^LVL_W-1
PER_W, 16, width of each decay period field, in ticks
TICK_CYCLES, 50_000_000, clk cycles per tick (1 s at 50 MHz)
HOLD_CYCLES, 250_000_000, continuous btn_test cycles that toggle test mode
HEALTH_PERIOD, 60, ticks per health step (decay or recovery)
CARE_STEP, 2, levels added per care event

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_test  in  1  active-high, already synchronised and debounced
btn_next  in  1  active-high, advance selected channel
btn_dec  in  1  active-high, test-mode decrement of selected channel
care_valid  in  1  one-cycle care event
care_ch  in  3  channel receiving care
decay_period  in  N_NEEDS*PER_W  per-channel decay period in ticks; ch i at [i*PER_W +: PER_W]; 0 = decay disabled
levels  out  N_NEEDS*LVL_W  need levels, same packing as decay_period
health  out  LVL_W  health level
sel  out  3  selected channel index
test_mode  out  1  test mode active
dead  out  1  sticky death flag
alarm  out  N_NEEDS  bit i = 1 when level i == 0
tick  out  1  one-cycle tick strobe

Behaviour:
- One clock domain. All state is synchronous, and reset is synchronous active-high. Reset may occur mid-operation and is obeyed in any state.
- Reset values:
  - every level = MAX; health = MAX
  - sel = 0; test_mode = 0; dead = 0; tick = 0; alarm = 0
  - all counters = 0
- Tick: cycle counter runs 0..TICK_CYCLES-1. tick = 1 for exactly the cycle the counter wraps.
- Decay, channel i:
  - A PER_W counter increments on each tick.
  - When the counter reaches decay_period_i-1 and a tick occurs: the counter clears, and level_i decrements if > 0 (saturates at 0).
  - decay_period_i == 0: the counter holds at 0 and no decay occurs.
  - A decay_period change takes effect on the next compare.
- Health:
  - A health counter advances on ticks.
  - At HEALTH_PERIOD ticks it clears, then:
    - if any alarm bit is set, health decrements;
    - otherwise health increments, saturating at MAX.
- Death:
  - health reaching 0 sets dead = 1 in the same cycle health is written to 0.
  - dead is sticky until reset.
  - While dead, levels, health, sel and test_mode freeze, and all inputs are ignored.
  - tick keeps running.
- Edge detection: btn_next and btn_dec act on rising edges only (registered previous value). A held button produces exactly one action.
- sel: a btn_next rise sets sel = (sel == N_NEEDS-1) ? 0 : sel+1.
- Test mode:
  - A hold counter counts cycles while btn_test = 1 and clears when btn_test = 0.
  - At HOLD_CYCLES-1, test_mode toggles and the counter clears. Continued holding toggles again every HOLD_CYCLES.
  - In test mode, a btn_dec rise decrements level[sel] if > 0; otherwise it decrements health directly.
  - Outside test mode, btn_dec is ignored.
- Care:
  - care_valid with care_ch < N_NEEDS: level[care_ch] = min(MAX, level + CARE_STEP), and that channel's decay counter clears.
  - care_ch >= N_NEEDS: the event is ignored.
- Same-cycle priority per channel: reset > dead-freeze > care > test decrement > decay. A lower-priority event that loses is discarded, not deferred.
- Health writes in the same cycle: a test decrement of health and a periodic health step combine as a net change with saturation.
- alarm is combinational from registered levels. levels and health have 0-cycle output latency from their registers.

Test Plan:
(Params for all scenarios: TICK_CYCLES=4, HOLD_CYCLES=8, HEALTH_PERIOD=3, N_NEEDS=5, LVL_W=3.)
- Reset; decay_period ch0 = 2, others = 0; run 16 cycles -> tick every 4th cycle; level0 = 5 after 4 ticks; other levels stay 7; health stays 7 (recovery saturates).
- Hold btn_test for 8 cycles -> test_mode = 1 on cycle 8. Hold 8 more -> test_mode = 0. Release at 7 -> no toggle.
- In test mode with sel = 0: 7 btn_dec pulses -> level0 = 0 and alarm[0] = 1. 7 further pulses -> health 7→0 and dead = 1. A subsequent btn_next or care event -> no change.
- btn_next held 20 cycles -> sel advances once. Five separate pulses from sel = 4 -> sel wraps to 0 on the first pulse.
- level2 = 6 and care_valid with care_ch = 2 in the same cycle as a decay compare -> level2 = 7 (saturated), decay dropped, counter = 0. care_ch = 6 -> ignored.
- Set ch1 to 0 via test mode, exit test mode, wait 3 ticks -> health decrements by 1. Assert reset mid-count -> all outputs return to reset values on the next clock.
